regfile_wport_arbiter: RTL and testbench

//  - Shares the single regfile write port (wb_we/wb_waddr/wb_wdata) between the in-order WB stage
//    and a multi-cycle result source (load-miss return / divider).
//  - WB always has priority. A multi-cycle result waits in a 1-entry buffer until the port is free.
//  - A scoreboard marks registers with an outstanding multi-cycle result. ID uses this to stall dependent reads.
//  - Sits between the WB stage and the regfile. Its wb_* outputs drive the regfile write/bypass inputs directly.

---
 rtl/cpu_defs_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 40 ++++
 rtl/regfile_wport_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared regfile widths and write-port arbiter state encoding
package cpu_defs_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_HOLD  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-result bit per register with two read lookups
module rf_scoreboard
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_hit,
    output logic              rd2_hit
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] pending;

    // Set is applied after clear so a same-address set/clear leaves the bit set.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[clr_addr] <= 1'b0;
            end
            if (set_en && (set_addr != '0)) begin
                pending[set_addr] <= 1'b1;
            end
        end
    end

    assign rd1_hit = (rd1_addr != '0) && pending[rd1_addr];
    assign rd2_hit = (rd2_addr != '0) && pending[rd2_addr];

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - shares the regfile write port between WB and a multi-cycle source
// Optional stall_cycles counter enabled by REGFILE_ARB_STATS_EN.
module regfile_wport_arbiter
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              mc_issue,
    input  logic [ADDR_W-1:0] mc_issue_addr,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_waddr,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              mc_ready,
    output logic              stall_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              rd1_hazard,
    output logic              rd2_hazard,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] FORCE_AT = CNT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    arb_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              pipe_live;
    logic              port_free;
    logic              drain;

    assign buf_full  = (state != ARB_IDLE);
    assign pipe_live = pipe_we && (pipe_waddr != ZERO_ADDR);
    assign port_free = !pipe_live;
    assign drain     = buf_full && port_free;
    assign mc_ready  = !buf_full;
    assign cnt_nxt   = wait_cnt + 1'b1;

    // Loading only happens from IDLE, so a drain and a load can never share a cycle.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= ARB_IDLE;
            wait_cnt  <= '0;
            stall_req <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (mc_valid) begin
                        buf_addr <= mc_waddr;
                        buf_data <= mc_wdata;
                        wait_cnt <= '0;
                        state    <= ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    if (port_free) begin
                        wait_cnt <= '0;
                        state    <= ARB_IDLE;
                    end else begin
                        wait_cnt <= cnt_nxt;
                        if (cnt_nxt >= FORCE_AT) begin
                            stall_req <= 1'b1;
                            state     <= ARB_FORCE;
                        end
                    end
                end
                ARB_FORCE: begin
                    if (port_free) begin
                        wait_cnt  <= '0;
                        stall_req <= 1'b0;
                        state     <= ARB_IDLE;
                    end
                end
                default: begin
                    wait_cnt  <= '0;
                    stall_req <= 1'b0;
                    state     <= ARB_IDLE;
                end
            endcase
        end
    end

    // Outputs are held quiet while reset is asserted, whatever the pipe presents.
    always_comb begin
        wb_we    = 1'b0;
        wb_waddr = '0;
        wb_wdata = '0;
        if (!reset_n) begin
            if (pipe_live) begin
                wb_we    = 1'b1;
                wb_waddr = pipe_waddr;
                wb_wdata = pipe_wdata;
            end else if (buf_full) begin
                wb_we    = 1'b1;
                wb_waddr = buf_addr;
                wb_wdata = buf_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (mc_issue),
        .set_addr (mc_issue_addr),
        .clr_en   (drain),
        .clr_addr (buf_addr),
        .rd1_addr (rd1_addr),
        .rd2_addr (rd2_addr),
        .rd1_hit  (rd1_hazard),
        .rd2_hit  (rd2_hazard)
    );

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            stall_cycles <= '0;
        end else if (stall_req && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb/tb_regfile_wport_arbiter.sv - scoreboard-driven self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;

    logic        clk;
    logic        reset_n;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mc_issue;
    logic [4:0]  mc_issue_addr;
    logic        mc_valid;
    logic [4:0]  mc_waddr;
    logic [31:0] mc_wdata;
    logic        mc_ready;
    logic        stall_req;
    logic [4:0]  rd1_addr;
    logic [4:0]  rd2_addr;
    logic        rd1_hazard;
    logic        rd2_hazard;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] stall_cycles;
`endif

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total;
    int  bad;

    regfile_wport_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pipe_we       (pipe_we),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .mc_issue      (mc_issue),
        .mc_issue_addr (mc_issue_addr),
        .mc_valid      (mc_valid),
        .mc_waddr      (mc_waddr),
        .mc_wdata      (mc_wdata),
        .mc_ready      (mc_ready),
        .stall_req     (stall_req),
        .rd1_addr      (rd1_addr),
        .rd2_addr      (rd2_addr),
        .rd1_hazard    (rd1_hazard),
        .rd2_hazard    (rd2_hazard),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic quiet_inputs();
        pipe_we       = 1'b0;
        pipe_waddr    = '0;
        pipe_wdata    = '0;
        mc_issue      = 1'b0;
        mc_issue_addr = '0;
        mc_valid      = 1'b0;
        mc_waddr      = '0;
        mc_wdata      = '0;
        rd1_addr      = '0;
        rd2_addr      = '0;
    endtask

    // Inputs change at negedge; outputs are sampled 2 time units later.
    task automatic test_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pipe_we       = 1'($urandom_range(0, 1));
            pipe_waddr    = 5'($urandom);
            pipe_wdata    = $urandom;
            mc_issue      = 1'($urandom_range(0, 1));
            mc_issue_addr = 5'($urandom);
            mc_valid      = 1'($urandom_range(0, 1));
            mc_waddr      = 5'($urandom);
            mc_wdata      = $urandom;
            rd1_addr      = 5'($urandom);
            rd2_addr      = 5'($urandom);
            #2;
            total++;
            if ({wb_we, mc_ready, stall_req, rd1_hazard, rd2_hazard} !== 5'b01000) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got we/rdy/stall/h1/h2=%b expected 01000", i,
                         {wb_we, mc_ready, stall_req, rd1_hazard, rd2_hazard});
            end
        end
        @(negedge clk);
        quiet_inputs();
        reset_n = 1'b0;
    endtask

    task automatic test_idle_port();
        wr_t e;
        @(negedge clk);
        quiet_inputs();
        mc_valid = 1'b1;
        mc_waddr = 5'd5;
        mc_wdata = 32'hDEADBEEF;
        #2;
        total++;
        if (wb_we !== 1'b0) begin
            bad++;
            $display("FAIL idle_accept_no_write got wb_we=%b expected 0", wb_we);
        end
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        @(negedge clk);
        quiet_inputs();
        #2;
        total++;
        if (wb_we !== 1'b1 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL idle_write_we got wb_we=%b expected 1", wb_we);
        end else begin
            e = exp_q.pop_front();
            if ({wb_waddr, wb_wdata} !== {e.addr, e.data}) begin
                bad++;
                $display("FAIL idle_write_data got r%0d=%h expected r%0d=%h", wb_waddr, wb_wdata, e.addr, e.data);
            end
        end
        @(negedge clk);
        #2;
        total++;
        if ({mc_ready, wb_we} !== 2'b10) begin
            bad++;
            $display("FAIL idle_buffer_empty got rdy/we=%b expected 10", {mc_ready, wb_we});
        end
    endtask

    task automatic test_conflict();
        wr_t e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            quiet_inputs();
            if (c < 4) begin
                pipe_we    = 1'b1;
                pipe_waddr = 5'd3;
                pipe_wdata = 32'h11;
                exp_q.push_back('{addr: 5'd3, data: 32'h11});
            end else begin
                exp_q.push_back('{addr: 5'd7, data: 32'h77});
            end
            if (c == 0) begin
                mc_valid = 1'b1;
                mc_waddr = 5'd7;
                mc_wdata = 32'h77;
            end
            #2;
            total++;
            if (wb_we !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL conflict_we cyc=%0d got wb_we=%b expected 1", c, wb_we);
            end else begin
                e = exp_q.pop_front();
                if ({wb_waddr, wb_wdata} !== {e.addr, e.data}) begin
                    bad++;
                    $display("FAIL conflict_data cyc=%0d got r%0d=%h expected r%0d=%h", c, wb_waddr, wb_wdata, e.addr, e.data);
                end
            end
            total++;
            if (stall_req !== (c == 4)) begin
                bad++;
                $display("FAIL conflict_stall cyc=%0d got %b expected %b", c, stall_req, (c == 4));
            end
        end
        @(negedge clk);
        quiet_inputs();
        #2;
        total++;
        if ({stall_req, wb_we, mc_ready} !== 3'b001) begin
            bad++;
            $display("FAIL conflict_after got stall/we/rdy=%b expected 001", {stall_req, wb_we, mc_ready});
        end
`ifdef REGFILE_ARB_STATS_EN
        total++;
        if (stall_cycles !== 16'd1) begin
            bad++;
            $display("FAIL stats_stall_cycles got %0d expected 1", stall_cycles);
        end
`endif
    endtask

    task automatic test_r0();
        wr_t e;
        @(negedge clk);
        quiet_inputs();
        pipe_we    = 1'b1;
        pipe_waddr = 5'd3;
        pipe_wdata = 32'h22;
        mc_valid   = 1'b1;
        mc_waddr   = 5'd9;
        mc_wdata   = 32'h55;
        exp_q.push_back('{addr: 5'd3, data: 32'h22});
        #2;
        total++;
        if (wb_we !== 1'b1 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL r0_load_we got wb_we=%b expected 1", wb_we);
        end else begin
            e = exp_q.pop_front();
            if ({wb_waddr, wb_wdata} !== {e.addr, e.data}) begin
                bad++;
                $display("FAIL r0_load_data got r%0d=%h expected r%0d=%h", wb_waddr, wb_wdata, e.addr, e.data);
            end
        end
        @(negedge clk);
        quiet_inputs();
        pipe_we       = 1'b1;
        pipe_waddr    = 5'd0;
        pipe_wdata    = 32'hAA;
        mc_issue      = 1'b1;
        mc_issue_addr = 5'd0;
        exp_q.push_back('{addr: 5'd9, data: 32'h55});
        #2;
        total++;
        if (wb_we !== 1'b1 || exp_q.size() == 0) begin
            bad++;
            $display("FAIL r0_drain_we got wb_we=%b expected 1", wb_we);
        end else begin
            e = exp_q.pop_front();
            if ({wb_waddr, wb_wdata} !== {e.addr, e.data}) begin
                bad++;
                $display("FAIL r0_drain_data got r%0d=%h expected r%0d=%h", wb_waddr, wb_wdata, e.addr, e.data);
            end
        end
        @(negedge clk);
        quiet_inputs();
        pipe_we    = 1'b1;
        pipe_waddr = 5'd0;
        pipe_wdata = 32'hBB;
        #2;
        total++;
        if ({wb_we, rd1_hazard, rd2_hazard, mc_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL r0_discard got we/h1/h2/rdy=%b expected 0001", {wb_we, rd1_hazard, rd2_hazard, mc_ready});
        end
    endtask

    // Each step: issue, valid result, expected rd1_hazard in this cycle.
    task automatic test_scoreboard();
        wr_t e;
        logic [31:0] rdata;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            quiet_inputs();
            rd1_addr = 5'd12;
            rd2_addr = 5'd13;
            mc_issue_addr = 5'd12;
            mc_waddr = 5'd12;
            rdata = 32'hC0 + 32'(c);
            mc_wdata = rdata;
            mc_issue = (c == 0) || (c == 6);
            mc_valid = (c == 2) || (c == 5) || (c == 8);
            if (c == 3 || c == 6 || c == 9) begin
                exp_q.push_back('{addr: 5'd12, data: 32'hC0 + 32'(c - 1)});
            end
            #2;
            total++;
            if (rd1_hazard !== (c inside {[1:3], 7, 8, 9})) begin
                bad++;
                $display("FAIL sb_hazard cyc=%0d got %b expected %b", c, rd1_hazard, (c inside {[1:3], 7, 8, 9}));
            end
            total++;
            if (rd2_hazard !== 1'b0) begin
                bad++;
                $display("FAIL sb_rd2_hazard cyc=%0d got %b expected 0", c, rd2_hazard);
            end
            if (c == 3 || c == 6 || c == 9) begin
                total++;
                if (wb_we !== 1'b1 || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_drain_we cyc=%0d got wb_we=%b expected 1", c, wb_we);
                end else begin
                    e = exp_q.pop_front();
                    if ({wb_waddr, wb_wdata} !== {e.addr, e.data}) begin
                        bad++;
                        $display("FAIL sb_drain_data cyc=%0d got r%0d=%h expected r%0d=%h", c, wb_waddr, wb_wdata, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        wr_t e;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            quiet_inputs();
            pipe_we    = 1'b1;
            pipe_waddr = 5'd3;
            pipe_wdata = 32'h33;
            rd1_addr   = 5'd4;
            mc_issue      = (c == 0);
            mc_issue_addr = 5'd4;
            mc_valid      = (c == 0);
            mc_waddr      = 5'd4;
            mc_wdata      = 32'h44;
            exp_q.push_back('{addr: 5'd3, data: 32'h33});
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, e.addr, e.data}) begin
                    bad++;
                    $display("FAIL midop_pipe cyc=%0d got we=%b r%0d=%h expected r%0d=%h", c, wb_we, wb_waddr, wb_wdata, e.addr, e.data);
                end
            end
        end
        total++;
        if ({mc_ready, rd1_hazard} !== 2'b01) begin
            bad++;
            $display("FAIL midop_before_reset got rdy/h1=%b expected 01", {mc_ready, rd1_hazard});
        end
        @(negedge clk);
        quiet_inputs();
        rd1_addr = 5'd4;
        reset_n  = 1'b1;
        #2;
        total++;
        if ({mc_ready, rd1_hazard, wb_we} !== 3'b100) begin
            bad++;
            $display("FAIL midop_in_reset got rdy/h1/we=%b expected 100", {mc_ready, rd1_hazard, wb_we});
        end
        @(negedge clk);
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #2;
            total++;
            if ({mc_ready, rd1_hazard, wb_we, stall_req} !== 4'b1000) begin
                bad++;
                $display("FAIL midop_after_reset cyc=%0d got rdy/h1/we/stall=%b expected 1000", c,
                         {mc_ready, rd1_hazard, wb_we, stall_req});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        quiet_inputs();
        test_reset();
        test_idle_port();
        test_conflict();
        test_r0();
        test_scoreboard();
        test_reset_midop();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
